// File: rtl/bin2bcd.sv
// ---------------------------------------------------------------------------
// bin2bcd
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per clock. A conversion of a BIN_W-bit value takes exactly
// BIN_W clock cycles. When start_en is tied to ~busy_o, conversions run
// back-to-back with a period of BIN_W+1 cycles.
//
// Ports:
//   clk       in   rising-edge system clock
//   rst_n     in   asynchronous active-low reset
//   start_en  in   start request, sampled only while idle
//   busy_o    out  high while a conversion is in progress
//   bin_i     in   unsigned binary operand [BIN_W-1:0], captured at start
//   bcd_o     out  packed BCD result [4*BCD_DIGITS-1:0], digit 0 in [3:0];
//                  updated only when a conversion completes
//
// Inputs that do not fit in BCD_DIGITS decimal digits wrap: any carry out of
// the top digit is dropped, so the result is BCD(bin mod 10^BCD_DIGITS).
// ---------------------------------------------------------------------------
module bin2bcd #(
  parameter int BIN_W      = 20,
  parameter int BCD_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_en,
  output logic                    busy_o,
  input  logic [BIN_W-1:0]        bin_i,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Counter value seen on the final iteration edge.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state_reg;
  logic [BIN_W-1:0]   shift_reg;   // remaining binary bits, MSB first
  logic [BCD_W-1:0]   acc_reg;     // BCD accumulator being built
  logic [BCD_W-1:0]   bcd_reg;     // last completed result
  logic [CNT_W-1:0]   cnt_reg;     // iterations done in this conversion
  logic               busy_reg;

  logic [BCD_W-1:0]   acc_adj;     // accumulator after add-3 correction
  logic [BCD_W-1:0]   acc_next;    // accumulator after correction + shift
  logic [BIN_W-1:0]   shift_next;

  // Per-digit add-3 correction. A digit >= 5 would become >= 10 after the
  // doubling shift; adding 3 first makes that doubling carry into the next
  // digit and leaves a valid 0..9 behind.
  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      logic [3:0] digit;
      assign digit               = acc_reg[gi*4 +: 4];
      assign acc_adj[gi*4 +: 4]  = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end
  endgenerate

  // Shift {acc, shift} left by one. The bit leaving the top digit is the
  // decimal carry out of the result width and is deliberately discarded.
  assign acc_next   = (acc_adj << 1) | BCD_W'(shift_reg[BIN_W-1]);
  assign shift_next = shift_reg << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_en) begin
            shift_reg <= bin_i;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= CONV;
          end
        end

        CONV: begin
          acc_reg   <= acc_next;
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_ITER) begin
            // Publish the fully shifted accumulator on the same edge that
            // performs the last iteration, so bcd_o is valid as busy drops.
            bcd_reg   <= acc_next;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_reg;
  assign bcd_o  = bcd_reg;

endmodule

// File: tb/tb_bin2bcd.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd
//
// Self-checking bench for bin2bcd. Expected results come from a decimal
// reference model (value mod 10^6, split into digits with / and %).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd;

  localparam int BIN_W      = 20;
  localparam int BCD_DIGITS = 6;
  localparam int CONV_CYC   = 20;
  localparam int PERIOD     = 21;

  logic                    clk;
  logic                    rst_n;
  logic                    start_en;
  logic                    busy_o;
  logic [BIN_W-1:0]        bin_i;
  logic [4*BCD_DIGITS-1:0] bcd_o;

  // start_en is either driven directly or tied to ~busy_o.
  logic start_drv;
  logic tie_mode;
  assign start_en = tie_mode ? ~busy_o : start_drv;

  int n_checks;
  int n_fail;

  bin2bcd #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_en (start_en),
    .busy_o   (busy_o),
    .bin_i    (bin_i),
    .bcd_o    (bcd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: packed BCD of (v mod 1000000).
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    int unsigned r;
    logic [23:0] o;
    r = v % 1000000;
    o = '0;
    for (int d = 0; d < 6; d++) begin
      o[d*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return o;
  endfunction

  // Runs one conversion. Reports the result, how many falling edges busy_o
  // stayed high, and whether bcd_o held its previous value while busy.
  // bin_i is scrambled during the conversion to show it is ignored.
  task automatic run_conv(input logic [19:0] v, output logic [23:0] res,
                          output int busy_cyc, output bit held);
    logic [23:0] prev;
    @(negedge clk);
    prev      = bcd_o;
    start_drv = 1'b1;
    bin_i     = v;
    @(negedge clk);
    start_drv = 1'b0;
    busy_cyc  = 0;
    held      = 1'b1;
    while (busy_o && busy_cyc < 100) begin
      busy_cyc++;
      if (bcd_o !== prev) held = 1'b0;
      bin_i     = 20'($urandom);
      start_drv = 1'($urandom);
      @(negedge clk);
    end
    start_drv = 1'b0;
    res = bcd_o;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start_drv = 1'b0;
    tie_mode  = 1'b0;
    bin_i     = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || bcd_o !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b bcd=%h required busy=0 bcd=000000", busy_o, bcd_o);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || bcd_o !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b bcd=%h required busy=0 bcd=000000", busy_o, bcd_o);
    end
    $display("test_reset: busy=%b bcd=%h", busy_o, bcd_o);
  endtask

  task automatic test_directed();
    logic [19:0] vals [6] = '{20'd12345, 20'd0, 20'd999999, 20'd9, 20'd10, 20'd99};
    logic [23:0] res;
    int          bc;
    bit          held;
    for (int i = 0; i < 6; i++) begin
      run_conv(vals[i], res, bc, held);
      n_checks++;
      if (res !== ref_bcd(vals[i])) begin
        n_fail++;
        $display("FAIL directed_result: bin=%0d got=%h required=%h", vals[i], res, ref_bcd(vals[i]));
      end
      n_checks++;
      if (bc !== CONV_CYC) begin
        n_fail++;
        $display("FAIL directed_latency: bin=%0d busy_cycles=%0d required=%0d", vals[i], bc, CONV_CYC);
      end
      n_checks++;
      if (!held) begin
        n_fail++;
        $display("FAIL directed_hold: bin=%0d bcd_o changed while busy", vals[i]);
      end
      $display("test_directed: bin=%0d bcd=%h busy_cycles=%0d", vals[i], res, bc);
    end
    // Idle with start_en low: result must hold.
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || bcd_o !== ref_bcd(99)) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b bcd=%h required busy=0 bcd=%h", busy_o, bcd_o, ref_bcd(99));
    end
  endtask

  task automatic test_overflow();
    logic [19:0] vals [3] = '{20'hFFFFF, 20'd1000000, 20'd1000001};
    logic [23:0] exp_v [3] = '{24'h048575, 24'h000000, 24'h000001};
    logic [23:0] res;
    int          bc;
    bit          held;
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], res, bc, held);
      n_checks++;
      if (res !== exp_v[i]) begin
        n_fail++;
        $display("FAIL overflow_result: bin=%0d got=%h required=%h", vals[i], res, exp_v[i]);
      end
      $display("test_overflow: bin=%0d bcd=%h", vals[i], res);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] q[$];
    logic [19:0] e;
    bit          prev_busy;
    int          last_start;
    int          n_done;
    int          wait_cyc;
    @(negedge clk);
    tie_mode   = 1'b1;
    prev_busy  = busy_o;
    last_start = -1;
    n_done     = 0;
    for (int cyc = 0; cyc < 6*PERIOD; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (prev_busy && !busy_o) begin
        e = q.pop_front();
        n_done++;
        n_checks++;
        if (bcd_o !== ref_bcd(e)) begin
          n_fail++;
          $display("FAIL b2b_result: bin=%0d got=%h required=%h", e, bcd_o, ref_bcd(e));
        end
        $display("test_back_to_back: bin=%0d bcd=%h", e, bcd_o);
      end
      bin_i = 20'($urandom);
      if (cyc == 6*PERIOD - 1) begin
        tie_mode = 1'b0;
      end else if (!busy_o) begin
        q.push_back(bin_i);
        if (last_start >= 0) begin
          n_checks++;
          if (cyc - last_start !== PERIOD) begin
            n_fail++;
            $display("FAIL b2b_period: got=%0d required=%0d", cyc - last_start, PERIOD);
          end
        end
        last_start = cyc;
      end
      prev_busy = busy_o;
    end
    tie_mode  = 1'b0;
    start_drv = 1'b0;
    // Drain a conversion still in flight.
    if (q.size() > 0) begin
      wait_cyc = 0;
      while (busy_o && wait_cyc < 50) begin
        @(negedge clk);
        wait_cyc++;
      end
      e = q.pop_front();
      n_checks++;
      if (busy_o !== 1'b0 || bcd_o !== ref_bcd(e)) begin
        n_fail++;
        $display("FAIL b2b_drain: bin=%0d busy=%b got=%h required=%h", e, busy_o, bcd_o, ref_bcd(e));
      end
      n_done++;
    end
    n_checks++;
    if (n_done < 5) begin
      n_fail++;
      $display("FAIL b2b_count: completed=%0d required>=5", n_done);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] res;
    int          bc;
    bit          held;
    // Leave a nonzero result in bcd_o first.
    run_conv(20'd654321, res, bc, held);
    @(negedge clk);
    start_drv = 1'b1;
    bin_i     = 20'd777777;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || bcd_o !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: busy=%b bcd=%h required busy=0 bcd=000000", busy_o, bcd_o);
    end
    $display("test_reset_mid: busy=%b bcd=%h", busy_o, bcd_o);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv(20'd31415, res, bc, held);
    n_checks++;
    if (res !== ref_bcd(31415) || bc !== CONV_CYC) begin
      n_fail++;
      $display("FAIL reset_mid_after: got=%h cycles=%0d required=%h cycles=%0d",
               res, bc, ref_bcd(31415), CONV_CYC);
    end
    $display("test_reset_mid: after release bcd=%h", res);
  endtask

  task automatic test_random();
    logic [19:0] v;
    logic [23:0] res;
    int          bc;
    bit          held;
    for (int i = 0; i < 500; i++) begin
      v = 20'($urandom);
      run_conv(v, res, bc, held);
      n_checks++;
      if (res !== ref_bcd(v) || bc !== CONV_CYC || !held) begin
        n_fail++;
        $display("FAIL random: bin=%0d got=%h cycles=%0d held=%b required=%h cycles=%0d held=1",
                 v, res, bc, held, ref_bcd(v), CONV_CYC);
      end
      $display("test_random: bin=%0d bcd=%h", v, res);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
